// File: rtl/flash_rd_arb_pkg.sv
// Shared definitions for the flash read-port arbiter: widths, FSM encoding and defaults.
package flash_rd_arb_pkg;

  localparam int FLASH_ADDR_NBIT = 24;
  localparam int FLASH_DATA_NBIT = 8;
  localparam int FLASH_SCLK_DIV  = 4;
  localparam int FA_TIMEOUT_CYC  = 65535;

  typedef enum logic [2:0] {
    FA_ST_IDLE      = 3'd0,
    FA_ST_ISSUE     = 3'd1,
    FA_ST_WAIT_BUSY = 3'd2,
    FA_ST_WAIT_DONE = 3'd3,
    FA_ST_RESP      = 3'd4
  } fa_state_t;

  // Index width for an N-entry requester vector; never narrower than 1 bit.
  function automatic int fa_idx_nbit(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flash_rd_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module flash_rd_arb_rr_pick
  import flash_rd_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = fa_idx_nbit(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  assign any = |req;

  always_comb begin : pick
    int unsigned j;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/flash_rd_arb.sv
// Round-robin arbiter sharing the flash_ctrl read port among NREQ requesters (mclk domain).
// Optional watchdog enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_rd_arb
  import flash_rd_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int ADDR_NBIT   = FLASH_ADDR_NBIT,
  parameter int DATA_NBIT   = FLASH_DATA_NBIT,
  parameter int TIMEOUT_CYC = FA_TIMEOUT_CYC
) (
  input  logic                      mclk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_vld,
  input  logic [NREQ*ADDR_NBIT-1:0] req_addr,
  output logic [NREQ-1:0]           req_rdy,
  output logic [NREQ-1:0]           rsp_vld,
  output logic                      rsp_err,
  output logic [DATA_NBIT-1:0]      rsp_data,
  output logic                      fl_rd,
  output logic [ADDR_NBIT-1:0]      fl_raddr,
  input  logic                      fl_rstatus,
  input  logic [DATA_NBIT-1:0]      fl_rdata,
  input  logic                      fl_rdv,
  output logic [2:0]                dbg_state
);

  localparam int IW = fa_idx_nbit(NREQ);

  // Handshake: a requester holds req_vld and req_addr until it sees its req_rdy
  // bit for one cycle; the byte comes back later on its one-cycle rsp_vld bit,
  // with rsp_data/rsp_err meaningful only in that cycle.

  fa_state_t           state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       owner;
  logic [NREQ-1:0]     pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [ADDR_NBIT-1:0] pick_addr;

  flash_rd_arb_rr_pick #(.N(NREQ), .IW(IW)) u_rr_pick (
    .req (req_vld),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_addr = req_addr[int'(pick_idx)*ADDR_NBIT +: ADDR_NBIT];
  assign dbg_state = state;

`ifdef FLASH_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_fire;
  logic        err_q;
  assign wd_fire = (wd_cnt == 16'(TIMEOUT_CYC - 1));
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state    <= FA_ST_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      req_rdy  <= '0;
      rsp_vld  <= '0;
      rsp_data <= '0;
      fl_rd    <= 1'b0;
      fl_raddr <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
      wd_cnt   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      req_rdy <= '0;
      rsp_vld <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
      err_q <= 1'b0;
      if (state inside {FA_ST_ISSUE, FA_ST_WAIT_BUSY, FA_ST_WAIT_DONE}) wd_cnt <= wd_cnt + 16'd1;
      else wd_cnt <= '0;
`endif
      case (state)
        FA_ST_IDLE: begin
          // fl_rstatus gates the grant so an abandoned flash cycle drains first.
          if (pick_any && fl_rstatus) begin
            fl_raddr <= pick_addr;
            owner    <= pick_idx;
            req_rdy  <= pick_gnt;
            rr_ptr   <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            fl_rd    <= 1'b1;
            state    <= FA_ST_ISSUE;
          end
        end
        FA_ST_ISSUE: begin
          // rd is held until flash_ctrl's divider tick picks it up and it goes busy.
          if (!fl_rstatus) begin
            fl_rd <= 1'b0;
            state <= FA_ST_WAIT_BUSY;
          end
        end
        FA_ST_WAIT_BUSY: state <= FA_ST_WAIT_DONE;
        FA_ST_WAIT_DONE: begin
          // fl_rdv is a level from the last read; only trust it alongside idle status.
          if (fl_rstatus && fl_rdv) begin
            rsp_data <= fl_rdata;
            rsp_vld  <= NREQ'(1) << owner;
            state    <= FA_ST_RESP;
          end
        end
        FA_ST_RESP: state <= FA_ST_IDLE;
        default:    state <= FA_ST_IDLE;
      endcase
`ifdef FLASH_ARB_TIMEOUT_EN
      if (wd_fire && (state inside {FA_ST_ISSUE, FA_ST_WAIT_BUSY, FA_ST_WAIT_DONE})) begin
        fl_rd    <= 1'b0;
        rsp_data <= '0;
        rsp_vld  <= NREQ'(1) << owner;
        err_q    <= 1'b1;
        state    <= FA_ST_RESP;
      end
`endif
    end
  end

endmodule
